// File: rtl/musa_boot_loader.sv
// Framed byte-stream program loader: assembles big-endian words into imem
// from address 0 and holds the core in reset until the checksum verifies.
//
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   rx_data/valid/ready - incoming byte stream handshake
//   imem_addr/data/wren - one-cycle instruction memory write
//   core_rst_n          - active-low core reset, released on success
//   load_count          - words written in the current frame
//   done, error         - sticky success / reject flags
module musa_boot_loader #(
    parameter int ADDR_WIDTH = 18,
    parameter int MAX_WORDS  = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_data,
    output logic                  imem_wren,
    output logic                  core_rst_n,
    output logic [15:0]           load_count,
    output logic                  done,
    output logic                  error
);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_CHECK, S_RUN, S_ERROR
    } state_t;

    localparam logic [16:0] MAXW = 17'(MAX_WORDS);

    state_t                state_q, state_d;
    logic                  started_q, started_d;
    logic [15:0]           len_q, len_d;
    logic [7:0]            chk_q, chk_d;
    logic [1:0]            bcnt_q, bcnt_d;
    logic [23:0]           asm_q, asm_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           data_q, data_d;
    logic                  wren_q, wren_d;
    logic [15:0]           count_q, count_d;

    logic        accept;
    logic [15:0] len_full;

    // started_q keeps rx_ready low for the first cycle after reset.
    assign rx_ready = started_q && (state_q != S_RUN) && (state_q != S_ERROR);
    assign accept   = rx_valid && rx_ready;
    assign len_full = {len_q[7:0], rx_data};

    always_comb begin
        state_d   = state_q;
        started_d = 1'b1;
        len_d     = len_q;
        chk_d     = chk_q;
        bcnt_d    = bcnt_q;
        asm_d     = asm_q;
        addr_d    = addr_q;
        data_d    = data_q;
        wren_d    = 1'b0;
        count_d   = count_q;

        // Address and count advance on the edge that ends the write strobe.
        if (wren_q) begin
            addr_d  = addr_q + ADDR_WIDTH'(1);
            count_d = count_q + 16'd1;
        end

        if (accept) begin
            unique case (state_q)
                S_IDLE: begin
                    if (rx_data == 8'hA5) begin
                        state_d = S_LEN_HI;
                        chk_d   = 8'h00;
                    end
                end
                S_LEN_HI: begin
                    len_d   = {8'h00, rx_data};
                    chk_d   = chk_q ^ rx_data;
                    state_d = S_LEN_LO;
                end
                S_LEN_LO: begin
                    len_d  = len_full;
                    chk_d  = chk_q ^ rx_data;
                    bcnt_d = 2'd0;
                    if ({1'b0, len_full} > MAXW)
                        state_d = S_ERROR;
                    else if (len_full == 16'd0)
                        state_d = S_CHECK;
                    else
                        state_d = S_DATA;
                end
                S_DATA: begin
                    chk_d  = chk_q ^ rx_data;
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        data_d = {asm_q, rx_data};
                        wren_d = 1'b1;
                        // Previous word's count update has always landed
                        // by the time the next 4th byte arrives.
                        if (count_q + 16'd1 == len_q)
                            state_d = S_CHECK;
                    end else begin
                        asm_d = {asm_q[15:0], rx_data};
                    end
                end
                S_CHECK: begin
                    state_d = (rx_data == chk_q) ? S_RUN : S_ERROR;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            started_q <= 1'b0;
            len_q     <= '0;
            chk_q     <= '0;
            bcnt_q    <= '0;
            asm_q     <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            wren_q    <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            started_q <= started_d;
            len_q     <= len_d;
            chk_q     <= chk_d;
            bcnt_q    <= bcnt_d;
            asm_q     <= asm_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            wren_q    <= wren_d;
            count_q   <= count_d;
        end
    end

    assign imem_addr  = addr_q;
    assign imem_data  = data_q;
    assign imem_wren  = wren_q;
    assign load_count = count_q;
    assign done       = (state_q == S_RUN);
    assign error      = (state_q == S_ERROR);
    assign core_rst_n = (state_q == S_RUN);

endmodule
